// File: rtl/eregfile_pkg.sv
// Shared types and defaults for the parameterised register file.
package eregfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Address width for a given register count, never narrower than one bit.
    function automatic int addr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/eregfile_clear_seq.sv
// Clear sequencer: walks index 0..DEPTH-1 once per clr request, one entry per cycle.
module eregfile_clear_seq
    import eregfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_w(DEF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] idx
);

    clr_state_e    state, state_nx;
    logic [AW-1:0] idx_nx;

    // State and index registers; reset abandons any sweep in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next state: clr only starts a sweep from IDLE; the index stops at DEPTH-1.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                end
            end
            CLEAR: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + AW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/eregfile_param.sv
// Parameterised 1W/2R register file with registered reads, optional zero
// register, optional write-to-read forwarding and a sequenced clear.
module eregfile_param
    import eregfile_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   DEPTH    = DEF_DEPTH,
    parameter int   ZERO_REG = 0,
    parameter int   BYPASS   = 1,
    localparam int  AW       = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             clr,
    output logic             busy
);

    logic [WIDTH-1:0]            mem [DEPTH];
    logic [AW-1:0]               clr_idx;
    logic                        wa_valid;
    logic                        wr_ok;
    logic [1:0][AW-1:0]          ra_v;
    logic [1:0][WIDTH-1:0]       rd_nx;

    eregfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .busy  (busy),
        .idx   (clr_idx)
    );

    // A write lands only when nothing else owns the array and the target exists.
    assign wa_valid = (32'(wa) < DEPTH);
    assign wr_ok    = we && !busy && !clr && wa_valid && !((ZERO_REG != 0) && (wa == '0));
    assign ra_v     = {ra2, ra1};

    // Storage: sweep clears take the array exclusively, otherwise accepted writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy && (clr_idx == AW'(i)))
                    mem[i] <= '0;
                else if (wr_ok && (wa == AW'(i)))
                    mem[i] <= wd;
            end
        end
    end

    // Read select per port: out-of-range addresses match no entry and read 0.
    always_comb begin
        rd_nx = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ra_v[p] == AW'(i)) rd_nx[p] = mem[i];
            end
            if ((BYPASS != 0) && wr_ok && (wa == ra_v[p]))
                rd_nx[p] = wd;
            if (busy || ((ZERO_REG != 0) && (ra_v[p] == '0)))
                rd_nx[p] = '0;
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= rd_nx[0];
            rd2 <= rd_nx[1];
        end
    end

endmodule

// File: tb/tb_eregfile_param.sv
// Directed bench: four configurations share one stimulus stream.
//   u0: default   u1: BYPASS=0   u2: ZERO_REG=1   u3: DEPTH=5
module tb_eregfile_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we  = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] wa  = '0;
    logic [2:0] ra1 = '0;
    logic [2:0] ra2 = '0;
    logic [7:0] wd  = '0;

    logic [7:0] r1 [4];
    logic [7:0] r2 [4];
    logic       bz [4];

    int ncmp = 0;
    int nerr = 0;
    int c0   = 0;
    int c3   = 0;

    always #5 clk = ~clk;

    eregfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(r1[0]), .rd2(r2[0]), .clr(clr), .busy(bz[0]));
    eregfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(r1[1]), .rd2(r2[1]), .clr(clr), .busy(bz[1]));
    eregfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(r1[2]), .rd2(r2[2]), .clr(clr), .busy(bz[2]));
    eregfile_param #(.WIDTH(8), .DEPTH(5), .ZERO_REG(0), .BYPASS(1)) u3 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(r1[3]), .rd2(r2[3]), .clr(clr), .busy(bz[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_rd1_u%0d", d), r1[d], 0);
            chk($sformatf("rst_rd2_u%0d", d), r2[d], 0);
            chk($sformatf("rst_busy_u%0d", d), bz[d], 0);
        end
        tick();
        tick();
        rst = 1'b0;

        // write/read
        we = 1; wa = 3; wd = 8'd42; tick();
        wa = 5; wd = 8'd99; tick();
        we = 0; ra1 = 3; ra2 = 5; tick();
        chk("wr_rd1_u0", r1[0], 42);
        chk("wr_rd2_u0", r2[0], 99);
        chk("wr_rd1_u1", r1[1], 42);
        chk("wr_rd2_u2", r2[2], 99);
        chk("wr_rd1_u3", r1[3], 42);
        chk("wr_rd2_u3_oob", r2[3], 0);

        // same-cycle write/read of r3
        we = 1; wa = 3; wd = 8'd7; ra1 = 3; tick();
        chk("byp_rd1_u0", r1[0], 7);
        chk("nobyp_rd1_u1", r1[1], 42);
        chk("byp_rd1_u3", r1[3], 7);
        we = 0; tick();
        chk("nobyp_after_u1", r1[1], 7);

        // zero register
        we = 1; wa = 0; wd = 8'hFF; ra1 = 0; tick();
        chk("z_byp_u0", r1[0], 8'hFF);
        chk("z_nobyp_u1", r1[1], 0);
        chk("z_byp_u2", r1[2], 0);
        we = 0; tick();
        chk("z_rd_u0", r1[0], 8'hFF);
        chk("z_rd_u1", r1[1], 8'hFF);
        chk("z_rd_u2", r1[2], 0);

        // odd depth: address 6 does not exist in u3
        we = 1; wa = 6; wd = 8'h55; ra1 = 6; tick();
        chk("odd_byp_u0", r1[0], 8'h55);
        chk("odd_byp_u3", r1[3], 0);
        we = 0; tick();
        chk("odd_rd_u0", r1[0], 8'h55);
        chk("odd_rd_u3", r1[3], 0);

        // fill r0..r7 with 1..8
        for (int i = 0; i < 8; i++) begin
            we = 1; wa = 3'(i); wd = 8'(i + 1); tick();
        end
        we = 0; ra1 = 7; tick();
        chk("fill_r7_u0", r1[0], 8);

        // clear, with a coincident write that must lose
        clr = 1; we = 1; wa = 1; wd = 8'h77; ra1 = 3; tick();
        chk("clr_edge_rd1_u0", r1[0], 4);
        chk("clr_edge_rd1_u3", r1[3], 4);
        clr = 0;
        c0 = 0; c3 = 0;
        for (int k = 0; k < 12; k++) begin
            c0 += int'(bz[0]);
            c3 += int'(bz[3]);
            if (k == 1) chk("busy_read_u0", r1[0], 0);
            we  = (k < 4);
            wa  = 2;
            wd  = 8'hAA;
            clr = (k == 3);
            tick();
        end
        we = 0; clr = 0;
        chk("busy_cycles_u0", c0, 8);
        chk("busy_cycles_u3", c3, 5);
        chk("busy_end_u0", bz[0], 0);
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i); tick();
            chk($sformatf("clr_rd1_r%0d_u0", i), r1[0], 0);
            chk($sformatf("clr_rd2_r%0d_u0", 7 - i), r2[0], 0);
            chk($sformatf("clr_rd1_r%0d_u3", i), r1[3], 0);
        end

        // reset in the middle of a sweep
        for (int i = 0; i < 8; i++) begin
            we = 1; wa = 3'(i); wd = 8'(i + 1); tick();
        end
        we = 0; ra1 = 7; ra2 = 6; tick();
        chk("refill_r7_u0", r1[0], 8);
        clr = 1; tick();
        clr = 0; tick(); tick(); tick();
        chk("mid_busy_u0", bz[0], 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy_u0", bz[0], 0);
        chk("mid_rst_rd1_u0", r1[0], 0);
        chk("mid_rst_rd2_u0", r2[0], 0);
        tick();
        rst = 1'b0;
        we = 1; wa = 2; wd = 8'h3C; tick();
        we = 0;
        chk("post_rst_busy_u0", bz[0], 0);
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); tick();
            chk($sformatf("post_rst_r%0d_u0", i), r1[0], (i == 2) ? 32'h3C : 32'h0);
        end
        chk("no_resume_u0", bz[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
